// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - programmable tick / clock-enable generator with pause, load handshake and 50% square output
//
// Optional tick counter (TICKS output, TICKS_CLR input) is built when CLK_TICK_GEN_TICKCNT_EN is defined.
module clk_tick_gen #(
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIV_IN,
    output logic             LOAD_ACK,
    output logic             S,
    output logic             SQ,
`ifdef CLK_TICK_GEN_TICKCNT_EN
    output logic [15:0]      TICKS,
    input  logic             TICKS_CLR,
`endif
    output logic [WIDTH-1:0] CNT
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_m1;
    logic [WIDTH-1:0] div_new;
    logic             at_end;
    logic             wrap;

    // Terminal-count detection; div_q is never 0, so div_q-1 cannot underflow.
    always_comb begin
        div_m1  = div_q - ONE;
        at_end  = (CNT == div_m1);
        wrap    = EN && !LOAD && at_end;
        div_new = (DIV_IN == '0) ? ONE : DIV_IN;
    end

    // Period register: reloaded by LOAD, a zero request saturates to one cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            div_q <= DIV_RST;
        end else if (LOAD) begin
            div_q <= div_new;
        end
    end

    // Phase counter: restart on load, advance when enabled, hold while paused.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            CNT <= '0;
        end else if (LOAD) begin
            CNT <= '0;
        end else if (EN) begin
            if (at_end) begin
                CNT <= '0;
            end else begin
                CNT <= CNT + ONE;
            end
        end
    end

    // Tick and square outputs: tick only on a wrap, square flips on each tick and holds across loads.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            S  <= 1'b0;
            SQ <= 1'b0;
        end else begin
            S <= wrap;
            if (wrap) begin
                SQ <= ~SQ;
            end
        end
    end

    // Load acknowledge: high exactly in the cycle after an accepted load.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            LOAD_ACK <= 1'b0;
        end else begin
            LOAD_ACK <= LOAD;
        end
    end

`ifdef CLK_TICK_GEN_TICKCNT_EN
    // Tick counter: advances together with S, free-running 16-bit wrap, clear beats increment.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            TICKS <= 16'd0;
        end else if (TICKS_CLR) begin
            TICKS <= 16'd0;
        end else if (wrap) begin
            TICKS <= TICKS + 16'd1;
        end
    end
`endif

endmodule

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
- Parametrised tick/clock-enable generator; the next generation of the team's fixed 1 Hz divider.
- Period is run-time programmable through a load handshake, counting can be paused, and a 50% square output is added next to the single-cycle tick.
- Sits between the board clock and slow logic (counters, display scanners, debouncers), feeding them clock enables rather than derived clocks.

Parameters:
- WIDTH, 26: counter and divisor width in bits.
- DEFAULT_DIV, 50000000: period in CLK cycles after reset (50 MHz -> 1 Hz). Must be >= 1 and < 2^WIDTH.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- EN  in  1  count enable; low = pause.
- LOAD  in  1  request to load a new period from DIV_IN.
- DIV_IN  in  WIDTH  new period in cycles.
- LOAD_ACK  out  1  one-cycle acknowledge of an accepted load.
- S  out  1  tick: high exactly one cycle per period.
- SQ  out  1  square output; toggles once per period (output period = 2*DIV).
- CNT  out  WIDTH  current count value, 0..DIV-1.

Behaviour:
- State: CNT, DIV register, S, SQ and LOAD_ACK. All outputs are registers; there is no combinational path from inputs to outputs.
- Reset (RST_N=0 at a rising edge):
  - CNT=0, DIV=DEFAULT_DIV, S=0, SQ=0, LOAD_ACK=0.
  - Reset overrides LOAD and EN in the same cycle.
- Priority per edge: reset > LOAD > EN.
- LOAD=1:
  - DIV <= DIV_IN, except that 0 saturates to 1.
  - CNT <= 0, S <= 0, SQ holds, LOAD_ACK <= 1 on the next cycle.
  - Applies regardless of EN.
  - LOAD held high for k cycles reloads and restarts k times, so the counter sits at 0 with LOAD_ACK high each cycle.
- EN=1, LOAD=0:
  - If CNT == DIV-1: CNT <= 0, S <= 1, SQ <= ~SQ.
  - Otherwise: CNT <= CNT+1, S <= 0.
  - Latency: with DIV=P, starting from CNT=0, S goes high on the edge after the P-th counted cycle, then repeats every P cycles.
- EN=0, LOAD=0: CNT, SQ and DIV hold; S <= 0. Resuming continues from the held CNT; no phase loss.
- DIV=1: CNT stays 0, S is high every enabled cycle, SQ toggles every enabled cycle.
- Wrap-around: CNT never exceeds DIV-1 and never overflows WIDTH. Arithmetic is unsigned WIDTH-bit; the comparison is against DIV-1 computed in WIDTH bits, which is always >= 0 because DIV >= 1.
- LOAD_ACK is low in every cycle not immediately following an accepted LOAD.
- Reset mid-period discards the count; the first tick after reset arrives DEFAULT_DIV enabled cycles later.

Optional Feature:
- Macro: CLK_TICK_GEN_TICKCNT_EN.
- When defined:
  - Adds output TICKS (16 bits): counts S pulses and wraps at 65535 -> 0.
  - Adds input TICKS_CLR (1 bit): synchronous clear to 0; clear wins over a simultaneous increment.
  - TICKS resets to 0 on RST_N=0. LOAD does not clear TICKS.
- When undefined: neither port exists, and the logic and behaviour are otherwise identical.

Test Plan:
- Bench parameters: WIDTH=8, DEFAULT_DIV=5.
- Reset: RST_N=0 for 2 cycles, then 1 with EN=1 -> CNT counts 0,1,2,3,4,0; S high once per 5 cycles, first on the 5th edge after reset release; SQ toggles with each S pulse.
- Pause: EN=0 for 3 cycles at CNT=2 -> CNT held at 2, S=0; after EN=1, S fires 3 enabled cycles later (CNT 3,4 then wrap).
- Load: LOAD=1 with DIV_IN=3 at CNT=4 -> next cycle CNT=0, S=0, LOAD_ACK=1 for one cycle; thereafter S every 3 cycles. LOAD with DIV_IN=0 -> S high every enabled cycle.
- Priority: RST_N=0 with LOAD=1 and DIV_IN=7 -> DIV stays 5, LOAD_ACK=0. LOAD=1 with EN=0 -> load accepted and LOAD_ACK=1.
- Boundary: DIV_IN=255 -> CNT reaches 254 and wraps to 0 with S=1; no overflow to 255.
- CLK_TICK_GEN_TICKCNT_EN defined, DIV=1, EN=1 for 65537 cycles -> TICKS wraps to 1. TICKS_CLR asserted together with a tick -> TICKS=0.
